// File: rtl/batcharger_measfilt.sv
// Post-ADC measurement filter for the battery charger: block-averages V/I/T
// conversions and derives valid strobes, a primed flag and window alarms.
module batcharger_measfilt #(
  parameter int AVG_LOG2 = 2,
  parameter int ERRW     = 4
) (
  input  logic            clk,
  input  logic            rstz,
  input  logic            en,
  input  logic            vtok,
  input  logic            vmeasen,
  input  logic            imeasen,
  input  logic            tmeasen,
  input  logic [7:0]      vbat,
  input  logic [7:0]      ibat,
  input  logic [7:0]      tbat,
  input  logic [7:0]      vovp,
  input  logic [7:0]      tempmin,
  input  logic [7:0]      tempmax,
  output logic [7:0]      vbat_avg,
  output logic [7:0]      ibat_avg,
  output logic [7:0]      tbat_avg,
  output logic            vvalid,
  output logic            ivalid,
  output logic            tvalid,
  output logic            primed,
  output logic            ovflag,
  output logic            tfault,
  output logic [ERRW-1:0] errcnt
);

  localparam int AW = 8 + AVG_LOG2;
  localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((1 << AVG_LOG2) - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PRIME = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      sel;
  logic [2:0][7:0] din;
  logic            one_hot, active, accept, invalid;
  logic [2:0][7:0] avg_q, avg_d;
  logic [2:0]      valid_q, valid_d;
  logic [2:0]      seen_q, seen_d;
  logic            primed_q, primed_d;
  logic            ovflag_q, ovflag_d;
  logic            tfault_q, tfault_d;
  logic [ERRW-1:0] errcnt_q, errcnt_d;

  assign sel     = {tmeasen, imeasen, vmeasen};
  assign din     = {tbat, ibat, vbat};
  assign one_hot = (sel == 3'b001) || (sel == 3'b010) || (sel == 3'b100);
  // The first enabled cycle is still IDLE, so samples count from PRIME onwards.
  assign active  = en && (state_q != S_IDLE);
  assign accept  = active && vtok && one_hot;
  assign invalid = active && vtok && !one_hot;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_ch
      logic [AW-1:0] acc_q, acc_d, sum;
      logic [CW-1:0] cnt_q, cnt_d;
      logic [7:0]    ch_avg_q, ch_avg_d;
      logic          vld_q, vld_d;

      assign sum = acc_q + AW'(din[gi]);

      always_comb begin
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        ch_avg_d = ch_avg_q;
        vld_d    = 1'b0;
        if (!active) begin
          acc_d    = '0;
          cnt_d    = '0;
          ch_avg_d = '0;
        end else if (accept && sel[gi]) begin
          if (cnt_q == CNT_LAST) begin
            acc_d    = '0;
            cnt_d    = '0;
            ch_avg_d = sum[AVG_LOG2 +: 8];
            vld_d    = 1'b1;
          end else begin
            acc_d = sum;
            cnt_d = cnt_q + CW'(1);
          end
        end
      end

      always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
          acc_q    <= '0;
          cnt_q    <= '0;
          ch_avg_q <= '0;
          vld_q    <= 1'b0;
        end else begin
          acc_q    <= acc_d;
          cnt_q    <= cnt_d;
          ch_avg_q <= ch_avg_d;
          vld_q    <= vld_d;
        end
      end

      assign avg_q[gi]   = ch_avg_q;
      assign avg_d[gi]   = ch_avg_d;
      assign valid_q[gi] = vld_q;
      assign valid_d[gi] = vld_d;
    end
  endgenerate

  always_comb begin
    seen_d   = seen_q | valid_d;
    primed_d = primed_q | (&seen_d);
    errcnt_d = errcnt_q;
    ovflag_d = 1'b0;
    tfault_d = 1'b0;
    if (invalid && (errcnt_q != {ERRW{1'b1}})) begin
      errcnt_d = errcnt_q + ERRW'(1);
    end
    // Flags re-evaluate on their channel's update, and once when primed first rises.
    if (primed_d) begin
      ovflag_d = ovflag_q;
      tfault_d = tfault_q;
      if (valid_d[0] || !primed_q) begin
        ovflag_d = avg_d[0] > vovp;
      end
      if (valid_d[2] || !primed_q) begin
        tfault_d = (avg_d[2] < tempmin) || (avg_d[2] > tempmax);
      end
    end
    if (!active) begin
      seen_d   = '0;
      primed_d = 1'b0;
      errcnt_d = '0;
      ovflag_d = 1'b0;
      tfault_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  state_d = S_PRIME;
      S_PRIME: if (primed_d) state_d = S_RUN;
      S_RUN:   state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
    if (!en) begin
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state_q  <= S_IDLE;
      seen_q   <= '0;
      primed_q <= 1'b0;
      ovflag_q <= 1'b0;
      tfault_q <= 1'b0;
      errcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      seen_q   <= seen_d;
      primed_q <= primed_d;
      ovflag_q <= ovflag_d;
      tfault_q <= tfault_d;
      errcnt_q <= errcnt_d;
    end
  end

  assign vbat_avg = avg_q[0];
  assign ibat_avg = avg_q[1];
  assign tbat_avg = avg_q[2];
  assign vvalid   = valid_q[0];
  assign ivalid   = valid_q[1];
  assign tvalid   = valid_q[2];
  assign primed   = primed_q;
  assign ovflag   = ovflag_q;
  assign tfault   = tfault_q;
  assign errcnt   = errcnt_q;

endmodule

// File: tb/tb_batcharger_measfilt.sv
// Bench for batcharger_measfilt: directed table, corner sequences and random
// traffic compared every cycle against a sample-list reference model.
module tb_batcharger_measfilt;

  localparam int L      = 2;
  localparam int N      = 1 << L;
  localparam int ERRMAX = 15;

  logic       clk = 1'b0;
  logic       rstz, en, vtok, vmeasen, imeasen, tmeasen;
  logic [7:0] vbat, ibat, tbat, vovp, tempmin, tempmax;
  logic [7:0] vbat_avg, ibat_avg, tbat_avg;
  logic       vvalid, ivalid, tvalid, primed, ovflag, tfault;
  logic [3:0] errcnt;

  always #5 clk = ~clk;

  batcharger_measfilt #(.AVG_LOG2(L), .ERRW(4)) dut (
    .clk(clk), .rstz(rstz), .en(en), .vtok(vtok),
    .vmeasen(vmeasen), .imeasen(imeasen), .tmeasen(tmeasen),
    .vbat(vbat), .ibat(ibat), .tbat(tbat),
    .vovp(vovp), .tempmin(tempmin), .tempmax(tempmax),
    .vbat_avg(vbat_avg), .ibat_avg(ibat_avg), .tbat_avg(tbat_avg),
    .vvalid(vvalid), .ivalid(ivalid), .tvalid(tvalid),
    .primed(primed), .ovflag(ovflag), .tfault(tfault), .errcnt(errcnt)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: each channel keeps the list of samples in its open block.
  int blk[3][16];
  int nblk[3];
  int m_avg[3];
  bit m_valid[3];
  bit m_seen[3];
  bit m_primed, m_ov, m_tf, m_live;
  int m_err;

  function automatic void model_clear();
    for (int c = 0; c < 3; c++) begin
      nblk[c] = 0; m_avg[c] = 0; m_valid[c] = 0; m_seen[c] = 0;
    end
    m_primed = 0; m_ov = 0; m_tf = 0; m_err = 0;
  endfunction

  function automatic void model_reset();
    model_clear();
    m_live = 0;
  endfunction

  function automatic void model_edge();
    int nsel, ch, sum;
    bit was_primed;
    int d[3];
    d[0] = int'(vbat); d[1] = int'(ibat); d[2] = int'(tbat);
    for (int c = 0; c < 3; c++) m_valid[c] = 0;
    if (!(en && m_live)) begin
      model_clear();
    end else if (vtok) begin
      nsel = int'(vmeasen) + int'(imeasen) + int'(tmeasen);
      if (nsel == 1) begin
        ch = vmeasen ? 0 : (imeasen ? 1 : 2);
        blk[ch][nblk[ch]] = d[ch];
        nblk[ch]++;
        if (nblk[ch] == N) begin
          sum = 0;
          for (int k = 0; k < N; k++) sum += blk[ch][k];
          m_avg[ch] = sum / N;
          nblk[ch] = 0;
          m_valid[ch] = 1;
        end
      end else if (m_err < ERRMAX) begin
        m_err++;
      end
    end
    was_primed = m_primed;
    for (int c = 0; c < 3; c++) m_seen[c] = m_seen[c] | m_valid[c];
    m_primed = m_seen[0] && m_seen[1] && m_seen[2];
    if (!m_primed) begin
      m_ov = 0; m_tf = 0;
    end else begin
      if (m_valid[0] || !was_primed) m_ov = m_avg[0] > int'(vovp);
      if (m_valid[2] || !was_primed)
        m_tf = (m_avg[2] < int'(tempmin)) || (m_avg[2] > int'(tempmax));
    end
    m_live = en;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("vbat_avg", vbat_avg, m_avg[0]);
    chk("ibat_avg", ibat_avg, m_avg[1]);
    chk("tbat_avg", tbat_avg, m_avg[2]);
    chk("vvalid", vvalid, m_valid[0]);
    chk("ivalid", ivalid, m_valid[1]);
    chk("tvalid", tvalid, m_valid[2]);
    chk("primed", primed, m_primed);
    chk("ovflag", ovflag, m_ov);
    chk("tfault", tfault, m_tf);
    chk("errcnt", errcnt, m_err);
  endtask

  task automatic drive(input bit e, input bit tok, input logic [2:0] sel,
                       input logic [7:0] v, input logic [7:0] i, input logic [7:0] t);
    en = e; vtok = tok;
    vmeasen = sel[0]; imeasen = sel[1]; tmeasen = sel[2];
    vbat = v; ibat = i; tbat = t;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic samp(input logic [2:0] sel, input logic [7:0] d);
    drive(1, 1, sel, d, d, d);
    step();
  endtask

  typedef struct {
    bit         en;
    bit         tok;
    logic [2:0] sel;
    logic [7:0] v;
    int         e_vavg;
    bit         e_vvalid;
    int         e_err;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{1, 0, 3'b000, 8'd0,  0,  0, 0};
    tbl[1] = '{1, 1, 3'b001, 8'd10, 0,  0, 0};
    tbl[2] = '{1, 1, 3'b001, 8'd11, 0,  0, 0};
    tbl[3] = '{1, 1, 3'b001, 8'd12, 0,  0, 0};
    tbl[4] = '{1, 1, 3'b001, 8'd14, 11, 1, 0};
    tbl[5] = '{1, 0, 3'b000, 8'd0,  11, 0, 0};
    tbl[6] = '{1, 1, 3'b000, 8'h55, 11, 0, 1};
    tbl[7] = '{1, 1, 3'b011, 8'h99, 11, 0, 2};
    tbl[8] = '{1, 0, 3'b000, 8'd0,  11, 0, 2};

    // Reset with inputs toggling
    rstz = 0; vovp = 8'hFF; tempmin = 8'h00; tempmax = 8'hFF;
    model_reset();
    for (int k = 0; k < 4; k++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 1), 3'($urandom_range(0, 7)),
            8'($urandom), 8'($urandom), 8'($urandom));
      @(posedge clk); #1;
      check_all();
    end
    drive(0, 0, 3'b000, 0, 0, 0);
    rstz = 1;
    drive(0, 1, 3'b001, 8'h33, 0, 0);
    step();
    chk("idle_errcnt", errcnt, 0);
    chk("idle_vavg", vbat_avg, 0);
    drive(0, 0, 3'b000, 0, 0, 0);
    step();

    // Table: averaging and the first invalid samples
    for (int r = 0; r < 9; r++) begin
      drive(tbl[r].en, tbl[r].tok, tbl[r].sel, tbl[r].v, 8'h77, 8'h77);
      step();
      chk($sformatf("tbl%0d_vavg", r), vbat_avg, tbl[r].e_vavg);
      chk($sformatf("tbl%0d_vvalid", r), vvalid, tbl[r].e_vvalid);
      chk($sformatf("tbl%0d_err", r), errcnt, tbl[r].e_err);
    end
    chk("avg_iavg_zero", ibat_avg, 0);
    chk("avg_tavg_zero", tbat_avg, 0);

    // errcnt saturation, then a clean block proves accumulators untouched
    for (int k = 0; k < 20; k++) begin
      drive(1, 1, (k % 2) ? 3'b111 : 3'b000, 8'hEE, 8'hEE, 8'hEE);
      step();
    end
    chk("err_sat", errcnt, 15);
    samp(3'b001, 8'd20); samp(3'b001, 8'd20); samp(3'b001, 8'd20); samp(3'b001, 8'd24);
    chk("clean_vavg", vbat_avg, 21);
    chk("clean_vvalid", vvalid, 1);

    // Interleave V/I/T with T finishing last
    vovp = 8'hFF; tempmin = 8'h3D; tempmax = 8'h83;
    for (int k = 0; k < 4; k++) begin
      samp(3'b001, 8'h30);
      samp(3'b010, 8'h20);
      if (k == 3) chk("pre_primed", primed, 0);
      samp(3'b100, 8'h50);
    end
    chk("prime_tvalid", tvalid, 1);
    chk("prime_primed", primed, 1);
    chk("prime_tfault", tfault, 0);
    chk("prime_run", int'(dut.state_q), 2);   // RUN state
    for (int k = 0; k < 4; k++) begin
      if (k == 3) chk("hot_pre_tfault", tfault, 0);
      samp(3'b100, 8'h90);
    end
    chk("hot_tavg", tbat_avg, 8'h90);
    chk("hot_tfault", tfault, 1);

    // Over-voltage boundary, including truncation landing on the threshold
    vovp = 8'hD6;
    samp(3'b001, 8'hD6); samp(3'b001, 8'hD6); samp(3'b001, 8'hD6); samp(3'b001, 8'hD9);
    chk("ov_eq_vavg", vbat_avg, 8'hD6);
    chk("ov_eq_flag", ovflag, 0);
    samp(3'b001, 8'hD5); samp(3'b001, 8'hD7); samp(3'b001, 8'hD7); samp(3'b001, 8'hD9);
    chk("ov_gt_vavg", vbat_avg, 8'hD7);
    chk("ov_gt_vvalid", vvalid, 1);
    chk("ov_gt_flag", ovflag, 1);

    // Abort mid-block
    samp(3'b001, 8'h10); samp(3'b001, 8'h10); samp(3'b001, 8'h10);
    drive(0, 1, 3'b001, 8'h10, 0, 0); step();
    chk("abort_primed", primed, 0);
    drive(1, 0, 3'b000, 0, 0, 0); step();
    for (int k = 0; k < 4; k++) samp(3'b001, 8'h40);
    chk("abort_vavg", vbat_avg, 8'h40);
    chk("abort_primed_v", primed, 0);
    for (int k = 0; k < 4; k++) samp(3'b010, 8'h22);
    chk("abort_primed_i", primed, 0);
    for (int k = 0; k < 4; k++) samp(3'b100, 8'h60);
    chk("abort_primed_t", primed, 1);

    // Random traffic against the model
    for (int n = 0; n < 4000; n++) begin
      int r;
      logic [2:0] s;
      r = $urandom_range(0, 9);
      if (r < 7) s = 3'(1 << (r % 3));
      else if (r == 7) s = 3'b000;
      else s = 3'($urandom_range(3, 7)) | 3'b011;
      if ($urandom_range(0, 199) == 0) begin
        vovp = 8'($urandom); tempmin = 8'($urandom_range(0, 127));
        tempmax = 8'($urandom_range(128, 255));
      end
      drive($urandom_range(0, 99) != 0, $urandom_range(0, 1), s,
            8'($urandom), 8'($urandom), 8'($urandom));
      step();
      if ($urandom_range(0, 999) == 0) begin
        rstz = 0;
        #2;
        model_reset();
        check_all();
        @(posedge clk); #1;
        check_all();
        rstz = 1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
